// File: rtl/led_pattern_gen_pkg.sv
// Shared mode encodings and direction constants for the LED pattern generator.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_CHASE   = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts 0..PRESCALE-1 while enabled and emits a registered
// one-cycle tick after each wrap. A clear restarts the count without a tick.
module led_prescaler #(
  parameter int unsigned PRESCALE = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic wrap_c,
  output logic tick_o
);

  localparam int unsigned CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Next count; a clear outranks the wrap so no step is issued that cycle.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_c = en_i && !clr_i && (cnt_q == CNT_MAX);
    if (en_i) begin
      if (clr_i || wrap_c) cnt_d = '0;
      else                 cnt_d = cnt_q + CNT_W'(1);
      tick_d = wrap_c;
    end
  end

  // Prescaler state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT / CHASE / BLINK / BREATHE patterns stepped by
// a prescaler, all state frozen while the PLL is unlocked.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int unsigned N_LED    = 7,
  parameter int unsigned PRESCALE = 1000000,
  parameter int unsigned PWM_W    = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             locked,
  input  logic [1:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int unsigned POS_W = $clog2(N_LED);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_LED - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  mode_e            mode_c, mode_q, mode_d;
  logic             mode_chg_c;
  logic             step_c;
  logic [N_LED-1:0] step_q, step_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_LED-1:0] led_q, led_d;

  assign mode_c     = mode_e'(mode);
  assign mode_chg_c = locked && (mode_c != mode_q);

  led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (RST),
    .en_i   (locked),
    .clr_i  (mode_chg_c),
    .wrap_c (step_c),
    .tick_o (tick)
  );

  // Pattern next-state: mode change loads the initial state, otherwise step on wrap.
  always_comb begin
    mode_d    = mode_q;
    step_d    = step_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    duty_d    = duty_q;
    pwm_cnt_d = pwm_cnt_q;
    led_d     = led_q;
    if (locked) begin
      mode_d    = mode_c;
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      if (mode_chg_c) begin
        case (mode_c)
          MODE_COUNT:   begin step_d = '0; led_d = '0; end
          MODE_CHASE:   begin pos_d = '0; dir_d = DIR_UP; led_d = N_LED'(1); end
          MODE_BLINK:   led_d = '0;
          MODE_BREATHE: begin duty_d = '0; dir_d = DIR_UP; led_d = '0; end
          default:      ;
        endcase
      end else begin
        case (mode_q)
          MODE_COUNT: begin
            if (step_c) begin
              step_d = step_q + N_LED'(1);
              led_d  = step_d;
            end
          end
          MODE_CHASE: begin
            if (step_c) begin
              if (dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                  pos_d = pos_q - POS_W'(1);
                  dir_d = DIR_DOWN;
                end else begin
                  pos_d = pos_q + POS_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d = pos_q + POS_W'(1);
                  dir_d = DIR_UP;
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
              led_d = N_LED'(1) << pos_d;
            end
          end
          MODE_BLINK: begin
            if (step_c) led_d = ~led_q;
          end
          MODE_BREATHE: begin
            if (step_c) begin
              if (dir_q == DIR_UP) begin
                if (duty_q == DUTY_MAX) begin
                  duty_d = duty_q - PWM_W'(1);
                  dir_d  = DIR_DOWN;
                end else begin
                  duty_d = duty_q + PWM_W'(1);
                end
              end else begin
                if (duty_q == '0) begin
                  duty_d = duty_q + PWM_W'(1);
                  dir_d  = DIR_UP;
                end else begin
                  duty_d = duty_q - PWM_W'(1);
                end
              end
            end
            led_d = {N_LED{pwm_cnt_q < duty_d}};
          end
          default: ;
        endcase
      end
    end
  end

  // Pattern state registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      mode_q    <= MODE_COUNT;
      step_q    <= '0;
      pos_q     <= '0;
      dir_q     <= DIR_UP;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      step_q    <= step_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (N_LED=4, PRESCALE=4, PWM_W=2).
module tb_led_pattern_gen;
  import led_pattern_gen_pkg::*;

  logic       clk = 1'b0;
  logic       RST;
  logic       locked;
  logic [1:0] mode;
  logic [3:0] led;
  logic       tick;

  led_pattern_gen #(
    .N_LED    (4),
    .PRESCALE (4),
    .PWM_W    (2)
  ) dut (
    .clk    (clk),
    .RST    (RST),
    .locked (locked),
    .mode   (mode),
    .led    (led),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         pre;
    logic [3:0] led;
    int         gap;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [1:0] cur_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] m, input int pre, input logic [3:0] l, input int gap);
    vec_t v;
    v.mode = m; v.pre = pre; v.led = l; v.gap = gap;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] init_led(input logic [1:0] m);
    return (m == MODE_CHASE) ? 4'b0001 : 4'b0000;
  endfunction

  // Wait (bounded) for the next tick; n stays 0 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic mode_change(input logic [1:0] m);
    mode     = m;
    cur_mode = m;
    @(negedge clk);
    check("chg_tick", 32'(tick), 32'(1'b0));
    check("chg_led", 32'(led), 32'(init_led(m)));
  endtask

  task automatic run_rows(input int lo, input int hi);
    int n;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].mode != cur_mode) begin
        repeat (vecs[i].pre) @(negedge clk);
        mode_change(vecs[i].mode);
      end
      wait_tick(n);
      check($sformatf("gap[%0d]", i), 32'(n), 32'(vecs[i].gap));
      check($sformatf("led[%0d]", i), 32'(led), 32'(vecs[i].led));
    end
  endtask

  initial begin
    int n;
    int hi_cnt;
    int bad;
    int a_end, b_lo, b_end, c_lo, c_end;
    int exp_duty[7];
    exp_duty = '{0, 1, 2, 3, 2, 1, 0};

    RST      = 1'b0;
    locked   = 1'b1;
    mode     = MODE_COUNT;
    cur_mode = MODE_COUNT;

    for (int k = 1; k <= 16; k++) add(MODE_COUNT, 0, 4'(k % 16), 4);
    add(MODE_CHASE, 0, 4'b0010, 4); add(MODE_CHASE, 0, 4'b0100, 4);
    add(MODE_CHASE, 0, 4'b1000, 4); add(MODE_CHASE, 0, 4'b0100, 4);
    add(MODE_CHASE, 0, 4'b0010, 4); add(MODE_CHASE, 0, 4'b0001, 4);
    add(MODE_CHASE, 0, 4'b0010, 4);
    add(MODE_BLINK, 0, 4'b1111, 4); add(MODE_BLINK, 0, 4'b0000, 4);
    add(MODE_BLINK, 0, 4'b1111, 4); add(MODE_BLINK, 0, 4'b0000, 4);
    a_end = vecs.size() - 1;
    b_lo = vecs.size();
    add(MODE_COUNT, 0, 4'd1, 4); add(MODE_COUNT, 0, 4'd2, 4);
    b_end = vecs.size() - 1;
    c_lo = vecs.size();
    add(MODE_CHASE, 3, 4'b0010, 4); add(MODE_CHASE, 0, 4'b0100, 4);
    add(MODE_CHASE, 0, 4'b1000, 4);
    c_end = vecs.size() - 1;

    // Reset state, then release after 20 ns.
    @(negedge clk);
    check("rst_led", 32'(led), 32'(4'b0000));
    check("rst_tick", 32'(tick), 32'(1'b0));
    @(negedge clk);
    RST = 1'b1;

    // COUNT, CHASE and BLINK tick tables.
    run_rows(0, a_end);

    // Freeze mid-interval with BLINK at 0000; two counts remain afterwards.
    repeat (2) @(negedge clk);
    locked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("frz_led", 32'(led), 32'(4'b0000));
      check("frz_tick", 32'(tick), 32'(1'b0));
    end
    locked = 1'b1;
    wait_tick(n);
    check("frz_gap", 32'(n), 32'(2));
    check("frz_led_after", 32'(led), 32'(4'b1111));

    // BREATHE: high-cycle count per 4-cycle window equals the duty of that window.
    mode_change(MODE_BREATHE);
    hi_cnt = int'(led[0]);
    bad    = 0;
    for (int k = 0; k < 7; k++) begin
      n = 0;
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        if (led !== 4'b0000 && led !== 4'b1111) bad++;
        if (tick === 1'b1) begin
          n = i;
          break;
        end
        hi_cnt += int'(led[0]);
      end
      check($sformatf("brt_gap[%0d]", k), 32'(n), 32'(4));
      check($sformatf("brt_duty[%0d]", k), 32'(hi_cnt), 32'(exp_duty[k]));
      hi_cnt = int'(led[0]);
    end
    check("brt_uniform", 32'(bad), 32'(0));

    // COUNT, then a CHASE change landing on the prescaler's last count.
    run_rows(b_lo, b_end);
    run_rows(c_lo, c_end);

    // Asynchronous reset between edges mid-CHASE.
    @(negedge clk);
    #1 RST = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'(4'b0000));
    check("arst_tick", 32'(tick), 32'(1'b0));
    #1 RST = 1'b1;
    @(negedge clk);
    check("arst_restart_led", 32'(led), 32'(4'b0001));
    check("arst_restart_tick", 32'(tick), 32'(1'b0));
    wait_tick(n);
    check("arst_gap", 32'(n), 32'(4));
    check("arst_led_step", 32'(led), 32'(4'b0010));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
